motion_ramp_sched: RTL

- Segment scheduler that drives the signed 32-bit `velocity` input of `step_gen`.
- Accepts a stream of motion segments (acceleration, duration) over a valid/ready handshake.
- Integrates acceleration into velocity once per prescaled tick.
- Chains queued segments with no idle cycle, producing trapezoid/S-like profiles for one axis.

---
 rtl/motion_pkg.sv | 47 ++++
 rtl/motion_ramp_sched_tick_prescaler.sv | 37 +++
 rtl/motion_ramp_sched.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/motion_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : motion_pkg                                                   |
// | Description : Shared types, widths and the saturating velocity adder used  |
// |               by the motion segment scheduler.                             |
// | Contents    : VEL_W, DUR_W widths; state_t {IDLE, RUN}; segment_t          |
// |               {accel, dur}; sat_add() 33-bit add with +/-vmax clamp.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package motion_pkg;

  localparam int VEL_W = 32;
  localparam int DUR_W = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // accel is carried as raw bits; consumers reinterpret it as signed.
  typedef struct packed {
    logic [VEL_W-1:0] accel;
    logic [DUR_W-1:0] dur;
  } segment_t;

  // One extra bit of headroom means the sum can never wrap; the result is
  // then clamped symmetrically to [-vmax, +vmax].
  function automatic logic signed [VEL_W-1:0] sat_add(
    input logic signed [VEL_W-1:0] a,
    input logic signed [VEL_W-1:0] b,
    input logic        [VEL_W-1:0] vmax
  );
    logic signed [VEL_W:0] sum;
    logic signed [VEL_W:0] lim;
    sum = {a[VEL_W-1], a} + {b[VEL_W-1], b};
    lim = {1'b0, vmax};
    if (sum > lim) begin
      sat_add = vmax;
    end else if (sum < -lim) begin
      sat_add = -vmax;
    end else begin
      sat_add = sum[VEL_W-1:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/motion_ramp_sched_tick_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tick_prescaler                                               |
// | Description : Divides clk into a one-cycle tick every TICK_DIV enabled     |
// |               cycles. Counter sits at 0 while cleared so the first tick    |
// |               after enabling lands exactly TICK_DIV cycles later.          |
// | Ports       : clk, reset (sync, active-high), clear (sync restart to 0),   |
// |               en (count enable), tick (out, high on count==TICK_DIV-1).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tick_prescaler #(
  parameter int TICK_DIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= (r_count == C_LAST) ? '0 : r_count + CNT_W'(1);
    end
  end

  assign tick = en && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/motion_ramp_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : motion_ramp_sched                                            |
// | Description : Single-axis motion segment scheduler. Integrates segment     |
// |               acceleration into a saturated signed velocity once per tick  |
// |               and chains queued segments back-to-back with no gap.         |
// | Ports       : clk, reset (sync, active-high)                               |
// |               cmd_valid/cmd_ready/cmd_accel/cmd_dur : segment handshake    |
// |               abort     : level, zeroes velocity and flushes segments      |
// |               velocity  : signed velocity to step_gen                      |
// |               busy      : high while a segment is running                  |
// |               seg_done  : one-cycle pulse per completed segment            |
// |               underrun  : sticky, ran out of segments at nonzero velocity  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module motion_ramp_sched
  import motion_pkg::*;
#(
  parameter int               TICK_DIV = 50,
  parameter logic [VEL_W-1:0] VMAX     = 32'h7FFF_FFFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [VEL_W-1:0] cmd_accel,
  input  logic        [DUR_W-1:0] cmd_dur,
  input  logic                    abort,
  output logic signed [VEL_W-1:0] velocity,
  output logic                    busy,
  output logic                    seg_done,
  output logic                    underrun
);

  state_t                  r_state,      w_state_nx;
  logic signed [VEL_W-1:0] r_velocity,   w_velocity_nx;
  logic signed [VEL_W-1:0] r_act_accel,  w_act_accel_nx;
  logic        [DUR_W-1:0] r_remaining,  w_remaining_nx;
  segment_t                r_next,       w_next_nx;
  logic                    r_next_valid, w_next_valid_nx;
  logic                    r_seg_done,   w_seg_done_nx;
  logic                    r_underrun,   w_underrun_nx;

  logic                    w_accept;
  logic                    w_tick;
  logic                    w_run;
  logic                    w_presc_clear;
  segment_t                w_cmd_seg;

  assign w_run     = (r_state == RUN);
  assign cmd_ready = !abort && (!w_run || !r_next_valid);
  assign w_accept  = cmd_valid && cmd_ready;

  // A zero duration is normalised on entry so remaining never starts at 0.
  assign w_cmd_seg.accel = cmd_accel;
  assign w_cmd_seg.dur   = (cmd_dur == '0) ? DUR_W'(1) : cmd_dur;

  // Holding the prescaler clear in IDLE guarantees it is 0 on RUN entry.
  assign w_presc_clear = abort || !w_run;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (w_presc_clear),
    .en    (w_run),
    .tick  (w_tick)
  );

  always_comb begin
    w_state_nx      = r_state;
    w_velocity_nx   = r_velocity;
    w_act_accel_nx  = r_act_accel;
    w_remaining_nx  = r_remaining;
    w_next_nx       = r_next;
    w_next_valid_nx = r_next_valid;
    w_seg_done_nx   = 1'b0;
    w_underrun_nx   = r_underrun;

    if (abort) begin
      w_velocity_nx   = '0;
      w_next_valid_nx = 1'b0;
      w_state_nx      = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_act_accel_nx = w_cmd_seg.accel;
            w_remaining_nx = w_cmd_seg.dur;
            w_state_nx     = RUN;
          end
        end
        RUN: begin
          // Acceptance in RUN implies the next slot is empty.
          if (w_accept) begin
            w_next_nx       = w_cmd_seg;
            w_next_valid_nx = 1'b1;
          end
          if (w_tick) begin
            w_velocity_nx  = sat_add(r_velocity, r_act_accel, VMAX);
            w_remaining_nx = r_remaining - DUR_W'(1);
            if (r_remaining == DUR_W'(1)) begin
              w_seg_done_nx = 1'b1;
              if (r_next_valid) begin
                w_act_accel_nx  = r_next.accel;
                w_remaining_nx  = r_next.dur;
                w_next_valid_nx = 1'b0;
              end else if (w_accept) begin
                // Bypass: the incoming command goes straight to active.
                w_act_accel_nx  = w_cmd_seg.accel;
                w_remaining_nx  = w_cmd_seg.dur;
                w_next_valid_nx = 1'b0;
              end else begin
                w_state_nx = IDLE;
                if (w_velocity_nx != '0) begin
                  w_underrun_nx = 1'b1;
                end
              end
            end
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_velocity   <= '0;
      r_act_accel  <= '0;
      r_remaining  <= '0;
      r_next       <= '0;
      r_next_valid <= 1'b0;
      r_seg_done   <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_velocity   <= w_velocity_nx;
      r_act_accel  <= w_act_accel_nx;
      r_remaining  <= w_remaining_nx;
      r_next       <= w_next_nx;
      r_next_valid <= w_next_valid_nx;
      r_seg_done   <= w_seg_done_nx;
      r_underrun   <= w_underrun_nx;
    end
  end

  assign velocity = r_velocity;
  assign busy     = w_run;
  assign seg_done = r_seg_done;
  assign underrun = r_underrun;

endmodule
`default_nettype wire
